// File: rtl/vending_machine_param_pkg.sv
// ============================================================================
//  Module      : vending_machine_param_pkg
//  Description : Shared definitions for the multi-item vending controller:
//                coin encodings, coin unit values, state codes and the
//                coin-code-to-value helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vending_machine_param_pkg;

   // Coin codes on the acceptor / hopper interfaces
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5C   = 2'b01;
   localparam logic [1:0] COIN_10C  = 2'b10;
   localparam logic [1:0] COIN_25C  = 2'b11;

   // Coin values in 5c units
   localparam logic [2:0] VAL_5C    = 3'd1;
   localparam logic [2:0] VAL_10C   = 3'd2;
   localparam logic [2:0] VAL_25C   = 3'd5;

   // Controller state codes
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CREDIT = 2'd1;
   localparam logic [1:0] ST_VEND   = 2'd2;
   localparam logic [1:0] ST_CHANGE = 2'd3;

   // Translate a coin code into its value in 5c units
   function automatic logic [2:0] coin_value(input logic [1:0] code);
      logic [2:0] v;
      case (code)
         COIN_5C:  v = VAL_5C;
         COIN_10C: v = VAL_10C;
         COIN_25C: v = VAL_25C;
         default:  v = 3'd0;
      endcase
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vm_change_picker.sv
// ============================================================================
//  Module      : vm_change_picker
//  Description : Chooses the largest coin not exceeding the current credit
//                (25c, then 10c, then 5c). Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vm_change_picker
   import vending_machine_param_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] i_credit,
   output logic [1:0]          o_coin
);

   // Greedy pick: biggest coin that fits in the remaining credit
   always_comb begin
      if (i_credit >= CREDIT_W'(VAL_25C))
         o_coin = COIN_25C;
      else if (i_credit >= CREDIT_W'(VAL_10C))
         o_coin = COIN_10C;
      else if (i_credit >= CREDIT_W'(VAL_5C))
         o_coin = COIN_5C;
      else
         o_coin = COIN_NONE;
   end

endmodule

`default_nettype wire

// File: rtl/vending_machine_param.sv
// ============================================================================
//  Module      : vending_machine_param
//  Description : Parametrised multi-item vending controller. Accumulates
//                coin credit, vends the selected item when credit covers its
//                price, then returns change one coin per hopper handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vending_machine_param
   import vending_machine_param_pkg::*;
#(
   parameter int                              NUM_ITEMS  = 4,
   parameter int                              SEL_W      = 2,
   parameter int                              CREDIT_W   = 8,
   parameter int                              MAX_CREDIT = 20,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = {8'd8, 8'd5, 8'd4, 8'd3}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          in,
   input  logic [SEL_W-1:0]    sel,
   input  logic                sel_valid,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                out,
   output logic [SEL_W-1:0]    item,
   output logic [1:0]          change,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                coin_reject,
   output logic                sel_short
);

   logic [1:0]          r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [SEL_W-1:0]    r_item;
   logic                r_coin_reject;
   logic                r_sel_short;

   logic [1:0]          w_state_nxt;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic [SEL_W-1:0]    w_item_nxt;
   logic                w_reject_nxt;
   logic                w_short_nxt;

   logic                w_coin_present;
   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W-1:0] w_price;
   logic                w_sel_in_range;
   logic                w_sel_ok;
   logic [1:0]          w_pick;
   logic [CREDIT_W-1:0] w_pick_val;
   logic [CREDIT_W-1:0] w_credit_after_change;

   vm_change_picker #(
      .CREDIT_W (CREDIT_W)
   ) u_picker (
      .i_credit (r_credit),
      .o_coin   (w_pick)
   );

   // Coin valuation; the sum carries one extra bit so the ceiling test cannot wrap
   assign w_coin_present        = (in != COIN_NONE);
   assign w_coin_val            = CREDIT_W'(coin_value(in));
   assign w_sum                 = {1'b0, r_credit} + {1'b0, w_coin_val};
   assign w_pick_val            = CREDIT_W'(coin_value(w_pick));
   assign w_credit_after_change = r_credit - w_pick_val;

   // Price lookup; an index with no matching item marks the selection invalid
   always_comb begin
      w_price        = '0;
      w_sel_in_range = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (sel == SEL_W'(i)) begin
            w_price        = PRICES[i*CREDIT_W +: CREDIT_W];
            w_sel_in_range = 1'b1;
         end
      end
   end

   assign w_sel_ok = w_sel_in_range && (r_credit >= w_price);

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_item        <= '0;
         r_coin_reject <= 1'b0;
         r_sel_short   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_credit      <= w_credit_nxt;
         r_item        <= w_item_nxt;
         r_coin_reject <= w_reject_nxt;
         r_sel_short   <= w_short_nxt;
      end
   end

   // Next-state logic: cancel beats selection beats coin in IDLE/CREDIT
   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_item_nxt   = r_item;
      w_reject_nxt = 1'b0;
      w_short_nxt  = 1'b0;
      case (r_state)
         ST_IDLE, ST_CREDIT: begin
            if (cancel) begin
               w_reject_nxt = w_coin_present;
               w_state_nxt  = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
            end else if (sel_valid) begin
               w_reject_nxt = w_coin_present;
               if (w_sel_ok) begin
                  w_credit_nxt = r_credit - w_price;
                  w_item_nxt   = sel;
                  w_state_nxt  = ST_VEND;
               end else begin
                  w_short_nxt  = 1'b1;
               end
            end else if (w_coin_present) begin
               if (w_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                  w_credit_nxt = w_sum[CREDIT_W-1:0];
                  w_state_nxt  = ST_CREDIT;
               end else begin
                  w_reject_nxt = 1'b1;
               end
            end
         end
         ST_VEND: begin
            w_reject_nxt = w_coin_present;
            w_state_nxt  = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            w_reject_nxt = w_coin_present;
            if (change_ready) begin
               w_credit_nxt = w_credit_after_change;
               if (w_credit_after_change == '0)
                  w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode, driven only from registered state
   always_comb begin
      out         = (r_state == ST_VEND);
      item        = (r_state == ST_VEND) ? r_item : '0;
      change      = (r_state == ST_CHANGE) ? w_pick : COIN_NONE;
      busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);
      credit      = r_credit;
      coin_reject = r_coin_reject;
      sel_short   = r_sel_short;
   end

endmodule

`default_nettype wire

// File: tb/tb_vending_machine_param.sv
// ============================================================================
//  Module      : tb_vending_machine_param
//  Description : Directed, table-driven bench for vending_machine_param.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vending_machine_param;

   logic       clk;
   logic       rst;
   logic [1:0] in;
   logic [1:0] sel;
   logic       sel_valid;
   logic       cancel;
   logic       change_ready;
   logic       out;
   logic [1:0] item;
   logic [1:0] change;
   logic [7:0] credit;
   logic       busy;
   logic       coin_reject;
   logic       sel_short;

   int checks;
   int errors;

   // One cycle of stimulus and the outputs expected after the following edge
   typedef struct {
      logic [1:0] in;
      logic [1:0] sel;
      logic       sv;
      logic       cn;
      logic       rdy;
      logic [7:0] cr;
      logic       o;
      logic [1:0] it;
      logic [1:0] ch;
      logic       bz;
      logic       rj;
      logic       ss;
   } vec_t;

   vec_t vecs[$];

   vending_machine_param dut (
      .clk          (clk),
      .rst          (rst),
      .in           (in),
      .sel          (sel),
      .sel_valid    (sel_valid),
      .cancel       (cancel),
      .change_ready (change_ready),
      .out          (out),
      .item         (item),
      .change       (change),
      .credit       (credit),
      .busy         (busy),
      .coin_reject  (coin_reject),
      .sel_short    (sel_short)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle: credit | out | item | change | busy | coin_reject | sel_short
   function automatic logic [15:0] pack_outs();
      return {credit, out, item, change, busy, coin_reject, sel_short};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got cr=%0d o=%b it=%0d ch=%b bz=%b rj=%b ss=%b expected cr=%0d o=%b it=%0d ch=%b bz=%b rj=%b ss=%b",
                  name, act[15:8], act[7], act[6:5], act[4:3], act[2], act[1], act[0],
                  exp[15:8], exp[7], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic [1:0] i_in, input logic [1:0] i_sel, input logic i_sv,
                      input logic i_cn, input logic i_rdy, input logic [7:0] e_cr,
                      input logic e_o, input logic [1:0] e_it, input logic [1:0] e_ch,
                      input logic e_bz, input logic e_rj, input logic e_ss);
      vec_t v;
      v.in = i_in; v.sel = i_sel; v.sv = i_sv; v.cn = i_cn; v.rdy = i_rdy;
      v.cr = e_cr; v.o = e_o; v.it = e_it; v.ch = e_ch; v.bz = e_bz; v.rj = e_rj; v.ss = e_ss;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] i_in, input logic [1:0] i_sel, input logic i_sv,
                        input logic i_cn, input logic i_rdy);
      in = i_in; sel = i_sel; sel_valid = i_sv; cancel = i_cn; change_ready = i_rdy;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

      //   in    sel  sv  cn  rdy  credit out item chg  busy rej  short
      // Two 10c coins, buy item 0 (price 3), one 5c change
      add(2'b10, 2'd0, 0, 0, 0, 8'd2,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b10, 2'd0, 0, 0, 0, 8'd4,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b00, 2'd0, 1, 0, 0, 8'd1,  1, 2'd0, 2'b00, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 0, 8'd1,  0, 2'd0, 2'b01, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd0,  0, 2'd0, 2'b00, 0, 0, 0);
      // Five 25c coins: ceiling 20 reached exactly, fifth rejected; cancel refunds 4 x 25c
      add(2'b11, 2'd0, 0, 0, 0, 8'd5,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b11, 2'd0, 0, 0, 0, 8'd10, 0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b11, 2'd0, 0, 0, 0, 8'd15, 0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b11, 2'd0, 0, 0, 0, 8'd20, 0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b11, 2'd0, 0, 0, 0, 8'd20, 0, 2'd0, 2'b00, 0, 1, 0);
      add(2'b00, 2'd0, 0, 1, 0, 8'd20, 0, 2'd0, 2'b11, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd15, 0, 2'd0, 2'b11, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd10, 0, 2'd0, 2'b11, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd5,  0, 2'd0, 2'b11, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd0,  0, 2'd0, 2'b00, 0, 0, 0);
      // Credit 3, item 3 costs 8 -> sel_short, nothing changes
      add(2'b01, 2'd0, 0, 0, 0, 8'd1,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b01, 2'd0, 0, 0, 0, 8'd2,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b01, 2'd0, 0, 0, 0, 8'd3,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b00, 2'd3, 1, 0, 0, 8'd3,  0, 2'd0, 2'b00, 0, 0, 1);
      add(2'b00, 2'd0, 0, 0, 0, 8'd3,  0, 2'd0, 2'b00, 0, 0, 0);
      // Refund 3 with the hopper stalling for five cycles
      add(2'b00, 2'd0, 0, 1, 0, 8'd3,  0, 2'd0, 2'b10, 1, 0, 0);
      for (int k = 0; k < 5; k++)
         add(2'b00, 2'd0, 0, 0, 0, 8'd3, 0, 2'd0, 2'b10, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd1,  0, 2'd0, 2'b01, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd0,  0, 2'd0, 2'b00, 0, 0, 0);
      // Credit 4; coin + sel_valid + cancel on one edge: coin rejected, refund wins
      add(2'b10, 2'd0, 0, 0, 0, 8'd2,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b10, 2'd0, 0, 0, 0, 8'd4,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b01, 2'd0, 1, 1, 0, 8'd4,  0, 2'd0, 2'b10, 1, 1, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd2,  0, 2'd0, 2'b10, 1, 0, 0);
      add(2'b00, 2'd0, 0, 0, 1, 8'd0,  0, 2'd0, 2'b00, 0, 0, 0);
      // Exact-price purchase of item 1 (price 4), coin during VEND rejected, no change owed
      add(2'b10, 2'd0, 0, 0, 0, 8'd2,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b10, 2'd0, 0, 0, 0, 8'd4,  0, 2'd0, 2'b00, 0, 0, 0);
      add(2'b00, 2'd1, 1, 0, 0, 8'd0,  1, 2'd1, 2'b00, 1, 0, 0);
      add(2'b01, 2'd0, 0, 0, 0, 8'd0,  0, 2'd0, 2'b00, 0, 1, 0);
      add(2'b00, 2'd0, 0, 0, 0, 8'd0,  0, 2'd0, 2'b00, 0, 0, 0);

      // Reset state
      #2;
      chk("reset", pack_outs(), 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[n]) begin
         drive(vecs[n].in, vecs[n].sel, vecs[n].sv, vecs[n].cn, vecs[n].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", n), pack_outs(),
             {vecs[n].cr, vecs[n].o, vecs[n].it, vecs[n].ch, vecs[n].bz, vecs[n].rj, vecs[n].ss});
         @(negedge clk);
      end

      // Async reset in the middle of a refund
      drive(2'b11, 2'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_coin", pack_outs(), {8'd5, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      drive(2'b00, 2'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_change", pack_outs(), {8'd5, 1'b0, 2'd0, 2'b11, 1'b1, 1'b0, 1'b0});
      drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst", pack_outs(), 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", pack_outs(), 16'h0000);
      @(negedge clk);
      // A fresh coin after reset starts from zero credit
      drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("post_rst_coin", pack_outs(), {8'd1, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
